card_deal_sequencer: RTL and testbench

// - Owns the single random card source shared by the player hand and the dealer hand of the blackjack game.
// - Sequences the opening deal: player, player, dealer.
// - After the opening deal, arbitrates player-hit (enter) and dealer-draw (pass) requests.
// - Emits one card per grant as a value plus a destination strobe; the game FSM adds the card to the selected hand.
// - Replaces the direct key-edge clocking of hand registers with a fully synchronous, Clock-domain interface.

---
 rtl/bj_pkg.sv | 30 +++
 rtl/card_deal_sequencer_if.sv | 30 +++
 rtl/key_edge_sync.sv | 35 +++
 rtl/card_deal_sequencer.sv | 138 +++++++++++++
 tb/tb_card_deal_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/bj_pkg.sv
// rtl/bj_pkg.sv - shared blackjack constants, deal state encoding and card helpers
// Purpose: constants shared by the card sequencer, the game FSM and the score display.
// Contents: card width/limits, LFSR tap mask, deal FSM state type, LFSR step and card mapping.
package bj_pkg;

    localparam int                CARD_W    = 5;
    localparam logic [CARD_W-1:0] CARD_MAX  = 5'd10;
    localparam logic [CARD_W-1:0] BLACKJACK = 5'd21;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEAL_P1 = 3'd1,
        ST_DEAL_P2 = 3'd2,
        ST_DEAL_D1 = 3'd3,
        ST_READY   = 3'd4
    } deal_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // Nibbles 0..9 map to 1..10; 10..15 fold onto 10, so face cards weigh more.
    function automatic logic [CARD_W-1:0] card_from_nibble(input logic [3:0] n);
        return (n < 4'd10) ? ({1'b0, n} + 5'd1) : CARD_MAX;
    endfunction

endpackage

// File: rtl/card_deal_sequencer_if.sv
// rtl/card_deal_sequencer_if.sv - key/control inputs and card outputs of the deal sequencer
// Purpose: bundles the sequencer's request and card signals.
// Ports: enter_n/pass_n raw active-low keys, new_round pulse, round_over level;
//        card value, p_valid/d_valid destination strobes, busy, deal_done, cards_used.
// Modports: master = game side driving requests, slave = sequencer.
interface card_deal_sequencer_if;
    import bj_pkg::*;

    logic              enter_n;
    logic              pass_n;
    logic              new_round;
    logic              round_over;
    logic [CARD_W-1:0] card;
    logic              p_valid;
    logic              d_valid;
    logic              busy;
    logic              deal_done;
    logic [3:0]        cards_used;

    modport master (
        output enter_n, pass_n, new_round, round_over,
        input  card, p_valid, d_valid, busy, deal_done, cards_used
    );

    modport slave (
        input  enter_n, pass_n, new_round, round_over,
        output card, p_valid, d_valid, busy, deal_done, cards_used
    );

endinterface

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - 2-FF synchronizer and falling-edge pulse for a raw key
// Purpose: turns an asynchronous active-low key into a single-cycle request.
// Ports: i_clk, i_rst (async, active high), i_key_n raw key, o_req one-cycle request.
// A press becomes visible on o_req three cycles after the key level changes;
// holding the key yields only one pulse.
module key_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_req
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_req;

    // Chain resets to the released (high) level so reset never looks like a press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_req   <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_req   <= r_prev & ~r_sync2;
        end
    end

    assign o_req = r_req;

endmodule

// File: rtl/card_deal_sequencer.sv
// rtl/card_deal_sequencer.sv - shared card source, opening deal and hit/draw arbitration
// Purpose: owns the card LFSR, deals player/player/dealer on new_round, then serves
//          player-hit and dealer-draw requests one card per cycle.
// Ports: i_clk, i_rst (async, active high), bus (slave modport of card_deal_sequencer_if).
// Parameters: LFSR_SEED non-zero LFSR reset value, MAX_CARDS cards per round incl. deal.
module card_deal_sequencer
    import bj_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_CARDS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    card_deal_sequencer_if.slave bus
);

    localparam logic [3:0] MAX_C = 4'(MAX_CARDS);

    logic [15:0]       r_lfsr;
    deal_state_t       r_state;
    logic              r_p_pend;
    logic              r_d_pend;
    logic [CARD_W-1:0] r_card;
    logic              r_p_valid;
    logic              r_d_valid;
    logic              r_busy;
    logic              r_deal_done;
    logic [3:0]        r_cards_used;

    logic              w_p_req;
    logic              w_d_req;
    logic              w_p_want;
    logic              w_d_want;
    logic [CARD_W-1:0] w_card;

    key_edge_sync u_enter_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key_n (bus.enter_n),
        .o_req   (w_p_req)
    );

    key_edge_sync u_pass_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key_n (bus.pass_n),
        .o_req   (w_d_req)
    );

    // A fresh request is served in the same cycle it arrives, so it does not
    // need to pass through the pending flag first.
    assign w_p_want = r_p_pend | w_p_req;
    assign w_d_want = r_d_pend | w_d_req;
    assign w_card   = card_from_nibble(r_lfsr[3:0]);

    // Outputs are registered together with the state they belong to: the state
    // register always names what is currently being presented.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lfsr       <= LFSR_SEED;
            r_state      <= ST_IDLE;
            r_p_pend     <= 1'b0;
            r_d_pend     <= 1'b0;
            r_card       <= '0;
            r_p_valid    <= 1'b0;
            r_d_valid    <= 1'b0;
            r_busy       <= 1'b0;
            r_deal_done  <= 1'b0;
            r_cards_used <= '0;
        end else begin
            r_lfsr      <= lfsr_next(r_lfsr);
            r_card      <= '0;
            r_p_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_deal_done <= 1'b0;

            if (bus.new_round) begin
                // Restart from any state; the LFSR keeps running.
                r_state      <= ST_DEAL_P1;
                r_busy       <= 1'b1;
                r_p_valid    <= 1'b1;
                r_card       <= w_card;
                r_cards_used <= 4'd1;
                r_p_pend     <= 1'b0;
                r_d_pend     <= 1'b0;
            end else begin
                case (r_state)
                    ST_DEAL_P1: begin
                        r_state      <= ST_DEAL_P2;
                        r_p_valid    <= 1'b1;
                        r_card       <= w_card;
                        r_cards_used <= r_cards_used + 4'd1;
                    end
                    ST_DEAL_P2: begin
                        r_state      <= ST_DEAL_D1;
                        r_d_valid    <= 1'b1;
                        r_deal_done  <= 1'b1;
                        r_card       <= w_card;
                        r_cards_used <= r_cards_used + 4'd1;
                    end
                    ST_DEAL_D1: begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                    ST_READY: begin
                        if (bus.round_over || (r_cards_used >= MAX_C)) begin
                            r_p_pend <= 1'b0;
                            r_d_pend <= 1'b0;
                        end else if (w_p_want) begin
                            // Player wins a tie; a simultaneous dealer request waits one cycle.
                            r_p_valid    <= 1'b1;
                            r_card       <= w_card;
                            r_cards_used <= r_cards_used + 4'd1;
                            r_p_pend     <= 1'b0;
                            r_d_pend     <= w_d_want;
                        end else if (w_d_want) begin
                            r_d_valid    <= 1'b1;
                            r_card       <= w_card;
                            r_cards_used <= r_cards_used + 4'd1;
                            r_d_pend     <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.card       = r_card;
    assign bus.p_valid    = r_p_valid;
    assign bus.d_valid    = r_d_valid;
    assign bus.busy       = r_busy;
    assign bus.deal_done  = r_deal_done;
    assign bus.cards_used = r_cards_used;

endmodule

// File: tb/tb_card_deal_sequencer.sv
// tb/tb_card_deal_sequencer.sv - scoreboard bench for card_deal_sequencer
module tb_card_deal_sequencer;

    localparam logic [15:0] SEED = 16'h0005;
    localparam int          MAXC = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    card_deal_sequencer_if bus();

    card_deal_sequencer #(.LFSR_SEED(SEED), .MAX_CARDS(MAXC)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rounds, hand-out order and card values from the game rules.
    typedef struct {
        int       cyc;
        bit       to_dealer;
        bit [4:0] card;
    } exp_t;

    exp_t     exp_q[$];
    int       cyc = 0;
    bit [15:0] m_lfsr = SEED;
    int       m_phase = 0;   // 0 idle, 1..3 opening cards shown, 4 drawing
    bit       m_pp = 0, m_dp = 0;
    int       m_used = 0;
    bit [3:0] hist_e = '1, hist_p = '1;
    bit       exp_done = 0;
    bit       m_preq, m_dreq, m_give_p, m_give_d;
    bit [4:0] m_card;
    exp_t     m_e;

    function automatic bit [4:0] card_of(input bit [15:0] v);
        int n;
        n = int'(v[3:0]);
        return (n < 10) ? 5'(n + 1) : 5'd10;
    endfunction

    function automatic bit [15:0] step_lfsr(input bit [15:0] v);
        bit [15:0] mask;
        mask = (16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10);
        return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr = SEED; m_phase = 0; m_pp = 0; m_dp = 0; m_used = 0;
            hist_e = '1; hist_p = '1; exp_q.delete(); exp_done = 0; cyc = 0;
        end else begin
            cyc++;
            m_card = card_of(m_lfsr);
            m_lfsr = step_lfsr(m_lfsr);
            // A press seen by the sequencer now was a high->low change 3..4 samples ago.
            m_preq = hist_e[3] & ~hist_e[2];
            m_dreq = hist_p[3] & ~hist_p[2];
            hist_e = {hist_e[2:0], bus.enter_n};
            hist_p = {hist_p[2:0], bus.pass_n};
            m_give_p = 0; m_give_d = 0; exp_done = 0;
            if (bus.new_round) begin
                m_phase = 1; m_used = 0; m_pp = 0; m_dp = 0; m_give_p = 1;
            end else if (m_phase == 1) begin
                m_give_p = 1; m_phase = 2;
            end else if (m_phase == 2) begin
                m_give_d = 1; exp_done = 1; m_phase = 3;
            end else if (m_phase == 3) begin
                m_phase = 4;
            end else if (m_phase == 4) begin
                m_pp = m_pp | m_preq;
                m_dp = m_dp | m_dreq;
                if (bus.round_over || m_used >= MAXC) begin
                    m_pp = 0; m_dp = 0;
                end else if (m_pp) begin
                    m_give_p = 1; m_pp = 0;
                end else if (m_dp) begin
                    m_give_d = 1; m_dp = 0;
                end
            end
            if (m_give_p || m_give_d) begin
                m_used++;
                m_e.cyc = cyc; m_e.to_dealer = m_give_d; m_e.card = m_card;
                exp_q.push_back(m_e);
            end
        end
    end

    // Monitor: compares presented outputs with the model, popping card events.
    int   n_p = 0, n_d = 0;
    exp_t got_e;

    always @(negedge clk) begin
        check("busy", bus.busy, (m_phase >= 1 && m_phase <= 3));
        check("cards_used", bus.cards_used, m_used);
        check("deal_done", bus.deal_done, exp_done);
        check("strobe_excl", bus.p_valid & bus.d_valid, 0);
        if (bus.p_valid) n_p++;
        if (bus.d_valid) n_d++;
        if (bus.p_valid || bus.d_valid) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                checks++; errors++;
                $display("FAIL unexpected_strobe: p=%0d d=%0d card=%0d at cycle %0d", bus.p_valid, bus.d_valid, bus.card, cyc);
            end else begin
                got_e = exp_q.pop_front();
                check("strobe_dest", bus.d_valid, got_e.to_dealer);
                check("card_value", bus.card, got_e.card);
            end
        end else begin
            check("card_idle", bus.card, 0);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                checks++; errors++;
                $display("FAIL missing_strobe: no strobe, expected dealer=%0d card=%0d at cycle %0d", exp_q[0].to_dealer, exp_q[0].card, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int np0, nd0;

    initial begin
        bus.enter_n = 1'b1; bus.pass_n = 1'b1; bus.new_round = 1'b0; bus.round_over = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {bus.card, bus.p_valid, bus.d_valid, bus.busy, bus.deal_done, bus.cards_used}, 0);

        // Opening deal straight out of reset: first card from seed nibble 5.
        bus.new_round = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
        tick();
        bus.new_round = 1'b0;
        check("deal1_p", bus.p_valid, 1);
        check("first_card", bus.card, 6);
        check("deal1_busy", bus.busy, 1);
        tick(); check("deal2_p", bus.p_valid, 1);
        tick(); check("deal3_d", bus.d_valid, 1); check("deal3_done", bus.deal_done, 1);
        tick(); check("deal_end_busy", bus.busy, 0); check("deal_used", bus.cards_used, 3);

        // Simultaneous hit and draw.
        bus.enter_n = 1'b0; bus.pass_n = 1'b0;
        repeat (3) tick(); check("both_p_not_early", bus.p_valid, 0);
        tick(); check("both_p", bus.p_valid, 1);
        tick(); check("both_d", bus.d_valid, 1); check("both_used", bus.cards_used, 5);
        bus.enter_n = 1'b1; bus.pass_n = 1'b1;

        // Card limit reached: further hits are discarded.
        np0 = n_p;
        repeat (3) begin
            bus.enter_n = 1'b0; repeat (3) tick();
            bus.enter_n = 1'b1; repeat (3) tick();
        end
        repeat (4) tick();
        check("sat_no_p", n_p - np0, 0);
        check("sat_used", bus.cards_used, 5);

        // round_over drops a pending dealer draw.
        bus.new_round = 1'b1; tick(); bus.new_round = 1'b0;
        check("restart_used", bus.cards_used, 1);
        repeat (3) tick();
        nd0 = n_d;
        bus.enter_n = 1'b0; bus.pass_n = 1'b0;
        repeat (4) tick();
        bus.round_over = 1'b1;
        check("ro_p_served", bus.p_valid, 1);
        repeat (4) tick();
        bus.round_over = 1'b0; bus.enter_n = 1'b1; bus.pass_n = 1'b1;
        repeat (4) tick();
        check("ro_no_d", n_d - nd0, 0);
        bus.new_round = 1'b1; tick(); bus.new_round = 1'b0;
        check("fresh_p", bus.p_valid, 1); check("fresh_used1", bus.cards_used, 1);
        repeat (3) tick(); check("fresh_used3", bus.cards_used, 3);

        // Reset between the two player cards of a deal.
        bus.new_round = 1'b1; tick(); bus.new_round = 1'b0;
        check("rd_p1", bus.p_valid, 1);
        @(negedge clk); #2 rst = 1'b1;
        #1 check("rst_mid_outputs", {bus.card, bus.p_valid, bus.d_valid, bus.busy, bus.deal_done, bus.cards_used}, 0);
        np0 = n_p; nd0 = n_d;
        tick();
        @(negedge clk); #2 rst = 1'b0;
        repeat (6) tick();
        check("rst_no_strobe", (n_p - np0) + (n_d - nd0), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus.new_round = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 49) == 0) bus.round_over = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) bus.enter_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) bus.pass_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 599) == 0) begin
                @(negedge clk); #2 rst = 1'b1;
                @(negedge clk); #2 rst = 1'b0;
            end
            tick();
        end

        bus.new_round = 1'b0; bus.round_over = 1'b0; bus.enter_n = 1'b1; bus.pass_n = 1'b1;
        repeat (8) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
